// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file write-back queue: lane codes,
// the queue entry layout and the default geometry.
package reg_wb_pkg;

  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_AW    = 3;
  localparam int WBQ_DW    = 16;

  localparam logic [1:0] WEN_NONE = 2'b00;
  localparam logic [1:0] WEN_LO   = 2'b01;
  localparam logic [1:0] WEN_HI   = 2'b10;
  localparam logic [1:0] WEN_FULL = 2'b11;

  typedef struct packed {
    logic [WBQ_AW-1:0] dest;
    logic [WBQ_DW-1:0] data;
    logic [1:0]        mask;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_merge.sv
// Per-lane newest-match search over the pending write-back entries.
// Entries arrive ordered oldest (index 0) to newest; the output register is older still.
module wbq_fwd_merge
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW
) (
  input  logic [AW-1:0]    ent_dest [DEPTH],
  input  logic [DW-1:0]    ent_data [DEPTH],
  input  logic [1:0]       ent_mask [DEPTH],
  input  logic [DEPTH-1:0] ent_valid,
  input  logic [AW-1:0]    out_dest,
  input  logic [DW-1:0]    out_data,
  input  logic [1:0]       out_mask,
  input  logic [AW-1:0]    fwd_addr,
  output logic [DW-1:0]    fwd_data,
  output logic [1:0]       fwd_mask
);

  localparam int HB = DW / 2;

  logic [HB-1:0] lo_s;
  logic [HB-1:0] hi_s;
  logic [1:0]    m_s;
  logic          hit_s;

  // Walk candidates oldest to newest so the newest match per lane wins
  always_comb begin
    lo_s  = {HB{1'b0}};
    hi_s  = {HB{1'b0}};
    m_s   = WEN_NONE;
    hit_s = (out_mask != WEN_NONE) && (out_dest == fwd_addr);
    lo_s    = (hit_s && out_mask[0]) ? out_data[HB-1:0]  : lo_s;
    hi_s    = (hit_s && out_mask[1]) ? out_data[DW-1:HB] : hi_s;
    m_s[0]  = (hit_s && out_mask[0]) ? 1'b1 : m_s[0];
    m_s[1]  = (hit_s && out_mask[1]) ? 1'b1 : m_s[1];
    for (int i = 0; i < DEPTH; i++) begin
      hit_s  = ent_valid[i] && (ent_dest[i] == fwd_addr);
      lo_s   = (hit_s && ent_mask[i][0]) ? ent_data[i][HB-1:0]  : lo_s;
      hi_s   = (hit_s && ent_mask[i][1]) ? ent_data[i][DW-1:HB] : hi_s;
      m_s[0] = (hit_s && ent_mask[i][0]) ? 1'b1 : m_s[0];
      m_s[1] = (hit_s && ent_mask[i][1]) ? 1'b1 : m_s[1];
    end
    fwd_data = {hi_s, lo_s};
    fwd_mask = m_s;
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the register file write port, with pending-write forwarding.
// Optional macro WBQ_COALESCE_EN merges a new entry into a same-dest tail entry.
module reg_wb_queue
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_dest,
  input  logic [DW-1:0]            in_data,
  input  logic [1:0]               in_mask,
  input  logic                     drain_en,
  output logic [AW-1:0]            d,
  output logic [DW-1:0]            wr,
  output logic [1:0]               w_en,
  input  logic [AW-1:0]            fwd_addr,
  output logic [DW-1:0]            fwd_data,
  output logic [1:0]               fwd_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HB = DW / 2;

  logic [AW-1:0]    dest_r [DEPTH];
  logic [DW-1:0]    data_r [DEPTH];
  logic [1:0]       mask_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic             ready_en_r;
  logic [AW-1:0]    d_r;
  logic [DW-1:0]    wr_r;
  logic [1:0]       w_en_r;

  logic             push_s;
  logic             pop_s;
  logic             coal_s;
  logic             alloc_s;
  logic [AW-1:0]    ord_dest_s [DEPTH];
  logic [DW-1:0]    ord_data_s [DEPTH];
  logic [1:0]       ord_mask_s [DEPTH];
  logic [DEPTH-1:0] ord_valid_s;

  // ready_en_r keeps in_ready low through reset and for the first edge after release
  assign in_ready = ready_en_r & (count_r != CW'(DEPTH));
  assign push_s   = in_valid & in_ready & (in_mask != WEN_NONE);
  assign pop_s    = drain_en & (count_r != {CW{1'b0}});
  assign alloc_s  = push_s & ~coal_s;

`ifdef WBQ_COALESCE_EN
  logic [PW-1:0] last_s;
  logic [DW-1:0] merge_s;
  assign last_s = tail_r - PW'(1);

  // Merge into the tail unless that tail is the head leaving this cycle
  always_comb begin
    merge_s = {in_mask[1] ? in_data[DW-1:HB] : data_r[last_s][DW-1:HB],
               in_mask[0] ? in_data[HB-1:0]  : data_r[last_s][HB-1:0]};
    if (push_s && (count_r != {CW{1'b0}}) && (dest_r[last_s] == in_dest) &&
        !(pop_s && (count_r == CW'(1)))) begin
      coal_s = 1'b1;
    end else begin
      coal_s = 1'b0;
    end
  end
`else
  assign coal_s = 1'b0;
`endif

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i] <= {AW{1'b0}};
        data_r[i] <= {DW{1'b0}};
        mask_r[i] <= WEN_NONE;
      end
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (alloc_s) begin
        dest_r[tail_r] <= in_dest;
        data_r[tail_r] <= in_data;
        mask_r[tail_r] <= in_mask;
        tail_r         <= tail_r + PW'(1);
      end
`ifdef WBQ_COALESCE_EN
      else if (coal_s) begin
        data_r[last_s] <= merge_s;
        mask_r[last_s] <= mask_r[last_s] | in_mask;
      end
`endif
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({alloc_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Register-file drive register; w_en is a single-cycle strobe per pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r    <= {AW{1'b0}};
      wr_r   <= {DW{1'b0}};
      w_en_r <= WEN_NONE;
    end else if (pop_s) begin
      d_r    <= dest_r[head_r];
      wr_r   <= data_r[head_r];
      w_en_r <= mask_r[head_r];
    end else begin
      w_en_r <= WEN_NONE;
    end
  end

  assign d     = d_r;
  assign wr    = wr_r;
  assign w_en  = w_en_r;
  assign count = count_r;

  // Present queue entries to the forwarding search in age order, head first
  always_comb begin
    ord_valid_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      ord_dest_s[i]  = dest_r[head_r + PW'(i)];
      ord_data_s[i]  = data_r[head_r + PW'(i)];
      ord_mask_s[i]  = mask_r[head_r + PW'(i)];
      ord_valid_s[i] = (CW'(i) < count_r);
    end
  end

  wbq_fwd_merge #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .ent_dest  (ord_dest_s),
    .ent_data  (ord_data_s),
    .ent_mask  (ord_mask_s),
    .ent_valid (ord_valid_s),
    .out_dest  (d_r),
    .out_data  (wr_r),
    .out_mask  (w_en_r),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .fwd_mask  (fwd_mask)
  );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: a vector table plus sequences for reset,
// forwarding merge and (optionally WBQ_COALESCE_EN) coalescing.
module tb_reg_wb_queue;
  import reg_wb_pkg::*;

`ifdef WBQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_dest;
  logic [15:0] in_data;
  logic [1:0]  in_mask;
  logic        drain_en;
  logic [2:0]  d;
  logic [15:0] wr;
  logic [1:0]  w_en;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic [1:0]  fwd_mask;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  reg_wb_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .in_mask(in_mask), .drain_en(drain_en),
    .d(d), .wr(wr), .w_en(w_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .fwd_mask(fwd_mask), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  dest;
    logic [15:0] data;
    logic [1:0]  mask;
    logic        drain;
    logic [2:0]  faddr;
    logic [2:0]  e_count;
    logic        e_ready;
    logic [1:0]  e_wen;
    logic [2:0]  e_d;
    logic [15:0] e_wr;
    logic [1:0]  e_fmask;
    logic [15:0] e_fdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic v, input logic [2:0] dst, input logic [15:0] dat,
                              input logic [1:0] m, input logic dr, input logic [2:0] fa,
                              input logic [2:0] ec, input logic er, input logic [1:0] ew,
                              input logic [2:0] ed, input logic [15:0] ewr,
                              input logic [1:0] efm, input logic [15:0] efd);
    vec_t t;
    t.vld = v; t.dest = dst; t.data = dat; t.mask = m; t.drain = dr; t.faddr = fa;
    t.e_count = ec; t.e_ready = er; t.e_wen = ew; t.e_d = ed; t.e_wr = ewr;
    t.e_fmask = efm; t.e_fdata = efd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] dst, input logic [15:0] dat,
                       input logic [1:0] m, input logic dr, input logic [2:0] fa);
    @(negedge clk);
    in_valid = v; in_dest = dst; in_data = dat; in_mask = m; drain_en = dr; fwd_addr = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; drain_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0000, WEN_NONE, 1'b0, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_dest = 3'd0; in_data = 16'h0000;
    in_mask = WEN_NONE; drain_en = 1'b0; fwd_addr = 3'd0;

    // Table: test 1, discarded mask, fill/refuse, full push+pop, lane merge with output reg
    vq.push_back(mk(1, 3'd3, 16'hBEEF, WEN_FULL, 1, 3'd3, 3'd1, 1, WEN_NONE, 3'd0, 16'h0000, WEN_FULL, 16'hBEEF));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 1, 3'd3, 3'd0, 1, WEN_FULL, 3'd3, 16'hBEEF, WEN_FULL, 16'hBEEF));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 1, 3'd3, 3'd0, 1, WEN_NONE, 3'd3, 16'hBEEF, WEN_NONE, 16'h0000));
    vq.push_back(mk(1, 3'd3, 16'h5555, WEN_NONE, 1, 3'd3, 3'd0, 1, WEN_NONE, 3'd3, 16'hBEEF, WEN_NONE, 16'h0000));
    vq.push_back(mk(1, 3'd1, 16'h1111, WEN_FULL, 0, 3'd1, 3'd1, 1, WEN_NONE, 3'd3, 16'hBEEF, WEN_FULL, 16'h1111));
    vq.push_back(mk(1, 3'd2, 16'h2222, WEN_FULL, 0, 3'd1, 3'd2, 1, WEN_NONE, 3'd3, 16'hBEEF, WEN_FULL, 16'h1111));
    vq.push_back(mk(1, 3'd4, 16'h4444, WEN_FULL, 0, 3'd1, 3'd3, 1, WEN_NONE, 3'd3, 16'hBEEF, WEN_FULL, 16'h1111));
    vq.push_back(mk(1, 3'd6, 16'h6666, WEN_FULL, 0, 3'd1, 3'd4, 0, WEN_NONE, 3'd3, 16'hBEEF, WEN_FULL, 16'h1111));
    vq.push_back(mk(1, 3'd7, 16'h7777, WEN_FULL, 0, 3'd7, 3'd4, 0, WEN_NONE, 3'd3, 16'hBEEF, WEN_NONE, 16'h0000));
    vq.push_back(mk(1, 3'd7, 16'h7777, WEN_FULL, 1, 3'd1, 3'd3, 1, WEN_FULL, 3'd1, 16'h1111, WEN_FULL, 16'h1111));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 1, 3'd7, 3'd2, 1, WEN_FULL, 3'd2, 16'h2222, WEN_NONE, 16'h0000));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 1, 3'd6, 3'd1, 1, WEN_FULL, 3'd4, 16'h4444, WEN_FULL, 16'h6666));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 1, 3'd6, 3'd0, 1, WEN_FULL, 3'd6, 16'h6666, WEN_FULL, 16'h6666));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 1, 3'd6, 3'd0, 1, WEN_NONE, 3'd6, 16'h6666, WEN_NONE, 16'h0000));
    vq.push_back(mk(1, 3'd4, 16'hAA55, WEN_HI,   0, 3'd4, 3'd1, 1, WEN_NONE, 3'd6, 16'h6666, WEN_HI,   16'hAA00));
    vq.push_back(mk(1, 3'd4, 16'h1234, WEN_LO,   1, 3'd4, 3'd1, 1, WEN_HI,   3'd4, 16'hAA55, WEN_FULL, 16'hAA34));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 1, 3'd4, 3'd0, 1, WEN_LO,   3'd4, 16'h1234, WEN_LO,   16'h0034));
    vq.push_back(mk(0, 3'd0, 16'h0000, WEN_NONE, 0, 3'd4, 3'd0, 1, WEN_NONE, 3'd4, 16'h1234, WEN_NONE, 16'h0000));

    // Reset state, including in_ready held low until one edge after release
    repeat (2) @(negedge clk);
    chk("rst_count", count, 3'd0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_wen", w_en, WEN_NONE);
    chk("rst_d", d, 3'd0);
    chk("rst_wr", wr, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", in_ready, 1'b0);
    drive(1'b0, 3'd0, 16'h0000, WEN_NONE, 1'b0, 3'd0);
    chk("ready_after_release", in_ready, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].vld, vq[i].dest, vq[i].data, vq[i].mask, vq[i].drain, vq[i].faddr);
      chk($sformatf("v%0d_count", i), count, vq[i].e_count);
      chk($sformatf("v%0d_ready", i), in_ready, vq[i].e_ready);
      chk($sformatf("v%0d_wen", i), w_en, vq[i].e_wen);
      chk($sformatf("v%0d_d", i), d, vq[i].e_d);
      chk($sformatf("v%0d_wr", i), wr, vq[i].e_wr);
      chk($sformatf("v%0d_fmask", i), fwd_mask, vq[i].e_fmask);
      chk($sformatf("v%0d_fdata", i), fwd_data, vq[i].e_fdata);
    end

    // Newest-first lane merge, miss lookup, then async reset mid-drain
    reset_dut();
    drive(1'b1, 3'd5, 16'h1234, WEN_FULL, 1'b0, 3'd5);
    drive(1'b1, 3'd5, 16'h00AB, WEN_LO,   1'b0, 3'd5);
    chk("fwd5_count", count, COAL ? 3'd1 : 3'd2);
    chk("fwd5_mask", fwd_mask, WEN_FULL);
    chk("fwd5_data", fwd_data, 16'h12AB);
    drive(1'b0, 3'd0, 16'h0000, WEN_NONE, 1'b0, 3'd6);
    chk("fwd6_mask", fwd_mask, WEN_NONE);
    chk("fwd6_data", fwd_data, 16'h0000);
    drive(1'b1, 3'd1, 16'h0101, WEN_FULL, 1'b0, 3'd5);
    drive(1'b1, 3'd2, 16'h0202, WEN_FULL, 1'b0, 3'd5);
    drive(1'b0, 3'd0, 16'h0000, WEN_NONE, 1'b1, 3'd5);
    chk("pre_rst_wen", w_en, WEN_FULL);
    chk("pre_rst_wr", wr, COAL ? 16'h12AB : 16'h1234);
    chk("pre_rst_count", count, COAL ? 3'd2 : 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", w_en, WEN_NONE);
    chk("mid_rst_d", d, 3'd0);
    chk("mid_rst_wr", wr, 16'h0000);
    chk("mid_rst_count", count, 3'd0);
    chk("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_fmask", fwd_mask, WEN_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, 16'h0000, WEN_NONE, 1'b1, 3'd5);
      chk($sformatf("post_rst%0d_wen", i), w_en, WEN_NONE);
      chk($sformatf("post_rst%0d_count", i), count, 3'd0);
    end

    // Two half-word writes to one register: merged or separate depending on build
    drive(1'b1, 3'd2, 16'h00CD, WEN_LO, 1'b0, 3'd2);
    drive(1'b1, 3'd2, 16'hEF00, WEN_HI, 1'b0, 3'd2);
    chk("coal_count", count, COAL ? 3'd1 : 3'd2);
    chk("coal_fmask", fwd_mask, WEN_FULL);
    chk("coal_fdata", fwd_data, 16'hEFCD);
    drive(1'b0, 3'd0, 16'h0000, WEN_NONE, 1'b1, 3'd2);
    chk("coal_w1_wen", w_en, COAL ? WEN_FULL : WEN_LO);
    chk("coal_w1_wr", wr, COAL ? 16'hEFCD : 16'h00CD);
    chk("coal_w1_d", d, 3'd2);
    chk("coal_w1_fdata", fwd_data, 16'hEFCD);
    drive(1'b0, 3'd0, 16'h0000, WEN_NONE, 1'b1, 3'd2);
    chk("coal_w2_wen", w_en, COAL ? WEN_NONE : WEN_HI);
    chk("coal_w2_wr", wr, COAL ? 16'hEFCD : 16'hEF00);
    chk("coal_w2_count", count, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-back initiator for the 8x16 general-purpose register file write port (d / wr / w_en).
- Buffers pipeline results in a small FIFO and drains one entry per cycle into the register file. Drive timing: outputs are registered so the file's posedge write sees stable values.
- Provides newest-first, byte-lane-merged forwarding of pending writes, so operand fetch can bypass not-yet-committed data.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- AW, 3, register address width (8 registers).
- DW, 16, data width; two byte lanes.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  result available.
- in_ready  output  1  queue can accept this cycle.
- in_dest  input  AW  destination register.
- in_data  input  DW  result data.
- in_mask  input  2  lane code: 11 = full word, 01 = low byte, 10 = high byte, 00 = no write.
- drain_en  input  1  permits popping head into the output register this cycle.
- d  output  AW  register file destination (registered).
- wr  output  DW  register file write data (registered).
- w_en  output  2  register file lane enable, same code as in_mask (registered).
- fwd_addr  input  AW  forwarding lookup address.
- fwd_data  output  DW  merged pending data for fwd_addr (combinational).
- fwd_mask  output  2  lanes valid in fwd_data; bit1 = high byte, bit0 = low byte.
- count  output  clog2(DEPTH)+1  queue occupancy, not including the output register.

Behaviour:
Reset (async, rst_n=0):
- Queue empties; count=0.
- d=0, wr=0, w_en=00.
- in_ready=1 one cycle after release; held at 0 while rst_n=0.
- Reset mid-drain discards all pending entries; no partial write is emitted.

Accept:
- Handshake when in_valid & in_ready at posedge.
- in_ready = (count != DEPTH); registered-free, derived from count.
- in_mask=00 handshakes complete but are discarded: no enqueue, count unchanged.

Drain:
- At each posedge, if drain_en and count>0, head pops into {d, wr, w_en}. Otherwise w_en <= 00 and d/wr hold their values.
- Latency: enqueue at edge N into an empty queue with drain_en high gives w_en valid after edge N+1; the register file commits at edge N+2.
- No same-cycle enqueue-to-output bypass.

Simultaneous push and pop:
- Allowed; count unchanged.
- When full, in_ready=0 even if a pop occurs in the same cycle.

Pointers:
- Wrap modulo DEPTH.
- count never exceeds DEPTH and never underflows.

Forwarding:
- Candidates: all valid queue entries plus the output register when w_en!=00.
- For each lane independently, select the newest candidate whose dest==fwd_addr and whose mask covers that lane. Age order: queue tail is newest, output register is oldest.
- fwd_mask bit set for each lane found; uncovered lanes of fwd_data = 0.
- A same-cycle incoming entry is not visible.

Optional Feature:
Macro WBQ_COALESCE_EN.
- Defined: an accepted entry whose in_dest equals the tail entry's dest merges into the tail instead of allocating.
  - Incoming lanes overwrite the tail's lanes.
  - Tail mask = OR of both masks.
  - count unchanged.
  - Not permitted when the tail is the head being popped this cycle; that case allocates normally.
  - in_ready stays (count != DEPTH), so a full queue still refuses.
- Undefined: every accepted entry with mask!=00 allocates its own slot.

Decomposition:
- Package reg_wb_pkg holds:
  - lane-code constants WEN_NONE=00, WEN_LO=01, WEN_HI=10, WEN_FULL=11;
  - entry typedef {dest, data, mask};
  - DEPTH/AW/DW defaults.
- One sub-module: wbq_fwd_merge, the combinational per-lane newest-match search over the entry array plus the output register.

Test Plan:
1. Reset then push R3=0xBEEF mask 11 with drain_en=1 -> w_en=11, d=3, wr=0xBEEF exactly one cycle later, then w_en=00.
2. drain_en=0; push 4 entries (DEPTH=4) -> count=4, in_ready=0. A fifth push is refused. Raise drain_en -> 4 consecutive writes in order, count falls to 0.
3. Pending R5=0x1234 mask 11 then R5=0x??AB mask 01; fwd_addr=5 -> fwd_data=0x12AB, fwd_mask=11. With fwd_addr=6 -> fwd_mask=00, fwd_data=0.
4. Full queue with simultaneous push attempt and pop -> pop completes, push refused, count 4->3.
5. Assert rst_n=0 while 3 entries are pending and w_en=11 -> outputs 0 and count=0 immediately; no write after release.
6. WBQ_COALESCE_EN: push R2=0x00CD mask 01 then R2=0xEF00 mask 10 with drain_en=0 -> count=1; drain gives w_en=11, wr=0xEFCD. Without the macro -> count=2 and two writes.
